// File: rtl/imsic_pkg.sv
// imsic_pkg: shared CSR addresses and scanner state encoding for the IMSIC interrupt file
package imsic_pkg;
   localparam logic [7:0] EIDELIVERY  = 8'h70;
   localparam logic [7:0] EITHRESHOLD = 8'h72;
   localparam logic [7:0] EIP0        = 8'h80;
   localparam logic [7:0] EIE0        = 8'hC0;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;
endpackage

// File: rtl/imsic_word_prienc.sv
// imsic_word_prienc: lowest-set-bit encoder for one 32-bit eligibility word
// i_word : candidate bits
// o_hit  : any bit set
// o_idx  : position of the lowest set bit (0 when none)
module imsic_word_prienc (
   input  logic [31:0] i_word,
   output logic        o_hit,
   output logic [4:0]  o_idx
);
   assign o_hit = |i_word;
   always_comb begin
      o_idx = '0;
      for (int b = 31; b >= 0; b--) if (i_word[b]) o_idx = 5'(b);
   end
endmodule

// File: rtl/imsic_intp_file.sv
// imsic_intp_file: one IMSIC interrupt file (eip/eie arrays, eidelivery, eithreshold, topei, claim)
// i_clk/i_rst          : clock, synchronous active-high reset
// i_setipnum(_we)      : identity to mark pending, one-cycle strobe
// i_csr_addr/we/wdata  : indirect CSR access (0x70 eidelivery, 0x72 eithreshold, 0x80+2k eip k, 0xC0+2k eie k)
// o_csr_rdata          : combinational read data for i_csr_addr
// i_claim              : topei write, clears the current top identity
// o_topei/o_busy/o_irq : top identity, scanner running, interrupt to hart
// IMSIC_FAST_TOPEI_EN  : full-width encoder registered every cycle instead of the word-serial scanner
module imsic_intp_file
   import imsic_pkg::*;
#(
   parameter  int NR_SRC     = 64,
   parameter  int NR_SRC_LEN = 32,
   localparam int NR_REG     = NR_SRC / 32,
   localparam int ID_W       = $clog2(NR_SRC)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NR_SRC_LEN-1:0] i_setipnum,
   input  logic                  i_setipnum_we,
   input  logic [7:0]            i_csr_addr,
   input  logic                  i_csr_we,
   input  logic [31:0]           i_csr_wdata,
   output logic [31:0]           o_csr_rdata,
   input  logic                  i_claim,
   output logic [ID_W-1:0]       o_topei,
   output logic                  o_busy,
   output logic                  o_irq
);
   localparam int IDX_W  = ID_W - 5;
   // RV64 layout: words sit on even addresses, so only 32 eip/eie words are reachable
   localparam int NR_CSR = (NR_REG < 32) ? NR_REG : 32;
   logic [NR_SRC-1:0] r_eip, r_eie, w_eip_nxt, w_eie_nxt;
   logic [ID_W-1:0]   r_thr, w_thr_nxt, r_topei, w_top_nxt;
   logic              r_eidel, w_eidel_nxt, r_irq, w_claim;
   assign o_topei = r_topei;
   assign o_irq   = r_irq;
   // later assignments win: CSR write < claim clear < setipnum set
   always_comb begin
      w_eip_nxt   = r_eip;
      w_eie_nxt   = r_eie;
      w_thr_nxt   = r_thr;
      w_eidel_nxt = r_eidel;
      o_csr_rdata = '0;
      if (i_csr_addr == EIDELIVERY) o_csr_rdata = {31'd0, r_eidel};
      if (i_csr_addr == EITHRESHOLD) o_csr_rdata = 32'(r_thr);
      if (i_csr_we && i_csr_addr == EIDELIVERY) w_eidel_nxt = i_csr_wdata[0];
      if (i_csr_we && i_csr_addr == EITHRESHOLD) w_thr_nxt = i_csr_wdata[ID_W-1:0];
      for (int j = 0; j < NR_CSR; j++) begin
         if (i_csr_addr == EIP0 + 8'(2 * j)) begin
            o_csr_rdata = r_eip[j*32 +: 32];
            if (i_csr_we) w_eip_nxt[j*32 +: 32] = i_csr_wdata;
         end
         if (i_csr_addr == EIE0 + 8'(2 * j)) begin
            o_csr_rdata = r_eie[j*32 +: 32];
            if (i_csr_we) w_eie_nxt[j*32 +: 32] = i_csr_wdata;
         end
      end
      if (w_claim) w_eip_nxt[r_topei] = 1'b0;
      if (i_setipnum_we && i_setipnum != '0 && i_setipnum < NR_SRC_LEN'(NR_SRC))
         w_eip_nxt[i_setipnum[ID_W-1:0]] = 1'b1;
      w_eip_nxt[0] = 1'b0;
      w_eie_nxt[0] = 1'b0;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_eip   <= '0;
         r_eie   <= '0;
         r_thr   <= '0;
         r_eidel <= 1'b0;
         r_topei <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_eip   <= w_eip_nxt;
         r_eie   <= w_eie_nxt;
         r_thr   <= w_thr_nxt;
         r_eidel <= w_eidel_nxt;
         r_topei <= w_top_nxt;
         r_irq   <= w_eidel_nxt && (w_top_nxt != '0);
      end
   end
`ifdef IMSIC_FAST_TOPEI_EN
   logic [NR_SRC-1:0] w_elig;
   logic [NR_REG-1:0] w_hit;
   logic [4:0]        w_pos [NR_REG];
   assign o_busy  = 1'b0;
   assign w_claim = i_claim;
   // encode from next-state arrays so o_topei follows any change after one edge
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NR_SRC; i++)
         w_elig[i] = w_eip_nxt[i] && w_eie_nxt[i] && (w_thr_nxt == '0 || ID_W'(i) < w_thr_nxt);
   end
   for (genvar g = 0; g < NR_REG; g++) begin : g_enc
      imsic_word_prienc u_enc (.i_word(w_elig[g*32 +: 32]), .o_hit(w_hit[g]), .o_idx(w_pos[g]));
   end
   always_comb begin
      w_top_nxt = '0;
      for (int j = NR_REG - 1; j >= 0; j--) if (w_hit[j]) w_top_nxt = {IDX_W'(j), w_pos[j]};
   end
`else
   scan_state_e      r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [ID_W-1:0]  r_best;
   logic [31:0]      w_word;
   logic [4:0]       w_pos;
   logic             r_dirty, r_claim_pend, w_hit, w_change;
   assign o_busy    = r_state != IDLE;
   assign w_claim   = (r_state == IDLE) && (i_claim || r_claim_pend);
   assign w_change  = (w_eip_nxt != r_eip) || (w_eie_nxt != r_eie) || (w_thr_nxt != r_thr);
   assign w_top_nxt = (r_state == DONE) ? r_best : r_topei;
   always_comb begin
      w_word = '0;
      for (int b = 0; b < 32; b++)
         w_word[b] = r_eip[{r_idx, 5'(b)}] && r_eie[{r_idx, 5'(b)}] && (r_thr == '0 || {r_idx, 5'(b)} < r_thr);
   end
   imsic_word_prienc u_enc (.i_word(w_word), .o_hit(w_hit), .o_idx(w_pos));
   // a pending change in SCAN discards this word and restarts at word 0
   always_comb begin
      w_state_nxt = (r_state == IDLE) ? (r_dirty ? SCAN : IDLE) :
                    (r_state == DONE) ? IDLE :
                    (!r_dirty && (w_hit || r_idx == IDX_W'(NR_REG - 1))) ? DONE : SCAN;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_best       <= '0;
         r_dirty      <= 1'b0;
         r_claim_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dirty      <= w_change || (r_dirty && r_state == DONE);
         r_claim_pend <= (r_state != IDLE) && (i_claim || r_claim_pend);
         if (r_state == IDLE || r_dirty) begin
            r_idx  <= '0;
            r_best <= '0;
         end else if (r_state == SCAN) begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_hit) r_best <= {r_idx, w_pos};
         end
      end
   end
`endif
endmodule

// File: tb/tb_imsic_intp_file.sv
// tb_imsic_intp_file: scoreboard bench for imsic_intp_file against a per-identity reference model
module tb_imsic_intp_file;
   localparam int NR_SRC = 64;
   localparam int NR_REG = NR_SRC / 32;
   localparam int ID_W   = 6;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     setipnum = '0;
   logic            set_we = 1'b0;
   logic [7:0]      addr = 8'h70;
   logic            we = 1'b0;
   logic [31:0]     wdata = '0;
   logic            claim = 1'b0;
   logic [31:0]     rdata;
   logic [ID_W-1:0] topei;
   logic            busy, irq;
   always #5 clk = ~clk;
   imsic_intp_file #(.NR_SRC(NR_SRC), .NR_SRC_LEN(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_setipnum(setipnum), .i_setipnum_we(set_we),
      .i_csr_addr(addr), .i_csr_we(we), .i_csr_wdata(wdata), .o_csr_rdata(rdata),
      .i_claim(claim), .o_topei(topei), .o_busy(busy), .o_irq(irq)
   );
   logic [NR_SRC-1:0] m_eip = '0, m_eie = '0;
   logic              m_del = 1'b0;
   logic [ID_W-1:0]   m_thr = '0;
   function automatic int m_top();
      for (int i = 1; i < NR_SRC; i++)
         if (m_eip[i] && m_eie[i] && (m_thr == '0 || i < 32'(m_thr))) return i;
      return 0;
   endfunction
   function automatic logic [31:0] m_rd(input logic [7:0] a);
      if (a == 8'h70) return {31'd0, m_del};
      if (a == 8'h72) return 32'(m_thr);
      for (int j = 0; j < NR_REG; j++) begin
         if (32'(a) == 32'h80 + 2 * j) return m_eip[j*32 +: 32];
         if (32'(a) == 32'hC0 + 2 * j) return m_eie[j*32 +: 32];
      end
      return '0;
   endfunction
   typedef struct {
      string           name;
      logic [ID_W-1:0] top;
      logic            irq;
      logic [31:0]     rd;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int   total = 0, bad = 0;
   logic chk_req = 1'b0;
   always @(negedge clk) begin
      if (chk_req) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: check requested with empty queue");
         end else begin
            e = q.pop_front();
            if (topei !== e.top || irq !== e.irq || rdata !== e.rd || busy !== 1'b0) begin
               bad++;
               $display("FAIL %s: got topei=%0d irq=%b rdata=%h busy=%b, want topei=%0d irq=%b rdata=%h busy=0",
                        e.name, topei, irq, rdata, busy, e.top, e.irq, e.rd);
            end
         end
      end
   end
   task automatic op(input logic s_we, input logic [31:0] s_val, input logic c_we,
                     input logic [7:0] c_a, input logic [31:0] c_d, input logic cl);
      int t;
      t = m_top();
      setipnum = s_val; set_we = s_we; addr = c_a; we = c_we; wdata = c_d; claim = cl;
      @(posedge clk); #1;
      set_we = 1'b0; we = 1'b0; claim = 1'b0;
      if (c_we) begin
         if (c_a == 8'h70) m_del = c_d[0];
         if (c_a == 8'h72) m_thr = c_d[ID_W-1:0];
         for (int j = 0; j < NR_REG; j++) begin
            if (32'(c_a) == 32'h80 + 2 * j) m_eip[j*32 +: 32] = c_d;
            if (32'(c_a) == 32'hC0 + 2 * j) m_eie[j*32 +: 32] = c_d;
         end
      end
      if (cl) m_eip[t] = 1'b0;
      if (s_we && s_val != 0 && s_val < NR_SRC) m_eip[s_val[ID_W-1:0]] = 1'b1;
      m_eip[0] = 1'b0;
      m_eie[0] = 1'b0;
   endtask
   task automatic csr(input logic [7:0] a, input logic [31:0] d);
      op(1'b0, '0, 1'b1, a, d, 1'b0);
   endtask
   task automatic setip(input logic [31:0] v);
      op(1'b1, v, 1'b0, 8'h70, '0, 1'b0);
   endtask
   task automatic do_claim();
      op(1'b0, '0, 1'b0, 8'h70, '0, 1'b1);
   endtask
   task automatic settle();
      repeat (NR_REG + 3) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [7:0] a);
      exp_t x;
      addr = a;
      x.name = n;
      x.top  = ID_W'(m_top());
      x.irq  = m_del && m_top() != 0;
      x.rd   = m_rd(a);
      q.push_back(x);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask
   task automatic wait_busy();
`ifndef IMSIC_FAST_TOPEI_EN
      int k = 0;
      while (!busy && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      if (!busy) begin
         total++;
         bad++;
         $display("FAIL wait_busy: busy=%b want 1 within 8 cycles", busy);
      end
`endif
   endtask
   logic [7:0] waddrs [6] = '{8'h80, 8'h82, 8'hC0, 8'hC2, 8'h81, 8'h84};
   logic [7:0] raddrs [8] = '{8'h70, 8'h72, 8'h80, 8'h82, 8'hC0, 8'hC2, 8'h81, 8'hC4};
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset", 8'h70);
      chk("reset_eip0", 8'h80);
      csr(8'hC0, 32'hFFFF_FFFE);
      csr(8'h70, 32'h1);
      setip(5);
      settle();
      chk("top5", 8'h80);
      do_claim();
      settle();
      chk("claim5", 8'h80);
      setip(12);
      settle();
      chk("top12", 8'h80);
      setip(9);
      wait_busy();
      do_claim();
      settle();
      settle();
      chk("deferred_claim", 8'h80);
      csr(8'hC0, 32'h0);
      csr(8'hC2, 32'h100);
      setip(40);
      setip(7);
      settle();
      chk("top40", 8'hC2);
      csr(8'h72, 32'd40);
      settle();
      chk("thr40", 8'h72);
      setip(0);
      setip(64);
      csr(8'h81, 32'hFFFF_FFFF);
      csr(8'hC1, 32'hFFFF_FFFF);
      settle();
      chk("odd_addr_read", 8'h81);
      chk("eip0_unchanged", 8'h80);
      chk("beyond_nr_reg", 8'h84);
      csr(8'h72, 32'd0);
      csr(8'hC0, 32'hFFFF_FFFE);
      csr(8'h80, 32'h0);
      setip(3);
      settle();
      chk("top3", 8'h80);
      op(1'b1, 32'd3, 1'b1, 8'h80, 32'h0, 1'b1);
      settle();
      chk("same_cycle", 8'h80);
      for (int it = 0; it < 30; it++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 3 && b == 0) do_claim();
            else if (kind == 1) csr(waddrs[$urandom_range(0, 5)], $urandom & $urandom & $urandom);
            else if (kind == 2) csr($urandom_range(0, 1) ? 8'h72 : 8'h70,
                                    $urandom_range(0, 1) ? 32'd0 : 32'($urandom_range(0, 63)));
            else setip($urandom_range(0, 70));
         end
         settle();
         chk("random", raddrs[$urandom_range(0, 7)]);
      end
      csr(8'hC2, 32'hFFFF_FFFF);
      wait_busy();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_eip = '0; m_eie = '0; m_del = 1'b0; m_thr = '0;
      chk("reset_mid_scan", 8'h70);
      chk("reset_mid_eie1", 8'hC2);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
